// File: rtl/mem_stage_lsu_if.sv
// Data-memory valid/ready bus between the MEM-stage LSU and data memory.
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues the data-memory transaction for the
// instruction held in EX/MEM, stalls upstream while memory is busy, aborts
// after TIMEOUT wait cycles, and holds the MEM/WB pipeline register.
//
//   state  | meaning
//   IDLE   | no transaction outstanding; zero-wait accesses complete here
//   WAIT   | request held on the bus, waiting for dmem_ready or timeout
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        StallM,
  mem_stage_lsu_if.master bus,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic        MisalignW,
  output logic        BusErrW
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic        is_store, is_load, is_access, misalign, go;
  logic        size_byte, size_half, size_word;
  logic [1:0]  off;
  logic        req_raw, stall_raw, done, abort;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  logic        regwrite_q, regwrite_d;
  logic [1:0]  resultsrc_q, resultsrc_d;
  logic [31:0] aluresult_q, aluresult_d;
  logic [31:0] readdata_q, readdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        misalign_q, misalign_d;
  logic        buserr_q, buserr_d;

  // A store takes priority over a load when both are flagged.
  assign is_store  = MemWriteM;
  assign is_load   = (ResultSrcM == 2'b01) && !MemWriteM;
  assign is_access = is_store || is_load;
  assign off       = ALUResultM[1:0];
  assign size_byte = (Funct3M[1:0] == 2'b00);
  assign size_half = (Funct3M[1:0] == 2'b01);
  assign size_word = !size_byte && !size_half;
  assign misalign  = is_access && ((size_half && off[0]) || (size_word && (off != 2'b00)));
  assign go        = is_access && !misalign;

  // Transaction sequencing; EX/MEM is frozen by StallM so the request stays stable.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          req_raw = 1'b1;
          if (bus.dmem_ready) begin
            done = 1'b1;
          end else begin
            stall_raw = 1'b1;
            state_d   = S_WAIT;
            cnt_d     = 8'd0;
          end
        end
      end
      S_WAIT: begin
        req_raw = 1'b1;
        if (bus.dmem_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset drops the request and stall immediately, abandoning any transaction.
  assign StallM         = stall_raw && !reset;
  assign bus.dmem_req   = req_raw && !reset;
  assign bus.dmem_we    = is_store;
  assign bus.dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign bus.dmem_wdata = wdata;
  assign bus.dmem_wstrb = wstrb;

  // Store lane replication and byte enables.
  always_comb begin
    wdata = WriteDataM;
    wstrb = 4'b0000;
    if (is_store) begin
      if (size_byte) begin
        wdata = {4{WriteDataM[7:0]}};
        wstrb = 4'b0001 << off;
      end else if (size_half) begin
        wdata = {2{WriteDataM[15:0]}};
        wstrb = 4'b0011 << off;
      end else begin
        wstrb = 4'b1111;
      end
    end
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    case (off)
      2'd0:    byte_sel = bus.dmem_rdata[7:0];
      2'd1:    byte_sel = bus.dmem_rdata[15:8];
      2'd2:    byte_sel = bus.dmem_rdata[23:16];
      default: byte_sel = bus.dmem_rdata[31:24];
    endcase
    half_sel = off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (Funct3M)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = bus.dmem_rdata;
    endcase
  end

  // MEM/WB next values: bubble while stalled, otherwise capture the M fields.
  always_comb begin
    regwrite_d  = regwrite_q;
    resultsrc_d = resultsrc_q;
    aluresult_d = aluresult_q;
    readdata_d  = readdata_q;
    rd_d        = rd_q;
    pcplus4_d   = pcplus4_q;
    misalign_d  = misalign_q;
    buserr_d    = buserr_q;
    if (StallM) begin
      regwrite_d  = 1'b0;
      resultsrc_d = 2'b00;
      misalign_d  = 1'b0;
      buserr_d    = 1'b0;
    end else begin
      regwrite_d  = RegWriteM && !misalign && !abort;
      resultsrc_d = ResultSrcM;
      aluresult_d = ALUResultM;
      readdata_d  = (done && is_load) ? load_ext : 32'd0;
      rd_d        = RdM;
      pcplus4_d   = PCPlus4M;
      misalign_d  = misalign;
      buserr_d    = abort;
    end
  end

  // FSM, wait counter and MEM/WB register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      regwrite_q  <= 1'b0;
      resultsrc_q <= 2'b00;
      aluresult_q <= 32'd0;
      readdata_q  <= 32'd0;
      rd_q        <= 5'd0;
      pcplus4_q   <= 32'd0;
      misalign_q  <= 1'b0;
      buserr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      aluresult_q <= aluresult_d;
      readdata_q  <= readdata_d;
      rd_q        <= rd_d;
      pcplus4_q   <= pcplus4_d;
      misalign_q  <= misalign_d;
      buserr_q    <= buserr_d;
    end
  end

  assign RegWriteW  = regwrite_q;
  assign ResultSrcW = resultsrc_q;
  assign ALUResultW = aluresult_q;
  assign ReadDataW  = readdata_q;
  assign RdW        = rd_q;
  assign PCPlus4W   = pcplus4_q;
  assign MisalignW  = misalign_q;
  assign BusErrW    = buserr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: the driver pushes the expected
// retirement of each instruction, the monitor checks bus, stall length and
// MEM/WB contents as the DUT presents them.
module tb_mem_stage_lsu;
  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        StallM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
  logic        MisalignW;
  logic        BusErrW;

  mem_stage_lsu_if bus();

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M), .StallM(StallM), .bus(bus),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        mis;
    logic        berr;
    int          stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: what the instruction should do, derived from access rules.
  function automatic exp_t model(input logic rw, input logic [1:0] rs, input logic mw,
                                 input logic [2:0] f3, input logic [31:0] alu,
                                 input logic [31:0] wd, input logic [4:0] rd,
                                 input logic [31:0] pc4, input logic [31:0] rdata,
                                 input int lat);
    exp_t e;
    logic st, ld, acc, mis, tmo;
    int off, sz;
    logic [31:0] v;
    st  = mw;
    ld  = (rs == 2'b01) && !mw;
    acc = st || ld;
    off = int'(alu % 4);
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis = acc && ((off % sz) != 0);
    tmo = acc && !mis && (lat < 0 || lat > TO);
    e.stall = (acc && !mis) ? (tmo ? TO : lat) : 0;
    e.rw   = rw && !mis && !tmo;
    e.rs   = rs;
    e.alu  = alu;
    e.rd   = rd;
    e.pc4  = pc4;
    e.mis  = mis;
    e.berr = tmo;
    e.rdata = 32'd0;
    if (ld && !mis && !tmo) begin
      v = rdata >> (8 * off);
      case (f3)
        3'b000: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFFFF00; end
        3'b100: v = v & 32'hFF;
        3'b001: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF0000; end
        3'b101: v = v & 32'hFFFF;
        default: v = rdata;
      endcase
      e.rdata = v;
    end
    e.req  = acc && !mis;
    e.we   = st;
    e.addr = alu - 32'(off);
    if (!st)          e.wstrb = 4'd0;
    else if (sz == 1) e.wstrb = 4'(1 << off);
    else if (sz == 2) e.wstrb = 4'(3 << off);
    else              e.wstrb = 4'hF;
    if (sz == 1)      e.wdata = (wd & 32'hFF) * 32'h01010101;
    else if (sz == 2) e.wdata = (wd & 32'hFFFF) * 32'h00010001;
    else              e.wdata = wd;
    return e;
  endfunction

  // Monitor: retire/bubble checks for the previous edge, then bus checks for this cycle.
  exp_t me;
  int   scnt = 0;
  logic cap_pend = 1'b0;
  logic stl_pend = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      scnt = 0;
      cap_pend = 1'b0;
      stl_pend = 1'b0;
    end else begin
      if (cap_pend) begin
        me = q.pop_front();
        chk("RegWriteW", RegWriteW, me.rw);
        chk("ResultSrcW", ResultSrcW, me.rs);
        chk("ALUResultW", ALUResultW, me.alu);
        chk("ReadDataW", ReadDataW, me.rdata);
        chk("RdW", RdW, me.rd);
        chk("PCPlus4W", PCPlus4W, me.pc4);
        chk("MisalignW", MisalignW, me.mis);
        chk("BusErrW", BusErrW, me.berr);
        cap_pend = 1'b0;
      end else if (stl_pend) begin
        chk("bubble_RegWriteW", RegWriteW, 0);
        chk("bubble_flags", {ResultSrcW, MisalignW, BusErrW}, 0);
        stl_pend = 1'b0;
      end
      if (q.size() > 0) begin
        me = q[0];
        chk("dmem_req", bus.dmem_req, me.req);
        if (bus.dmem_req) begin
          chk("dmem_addr", bus.dmem_addr, me.addr);
          chk("dmem_we", bus.dmem_we, me.we);
          chk("dmem_wstrb", bus.dmem_wstrb, me.wstrb);
          if (me.we) chk("dmem_wdata", bus.dmem_wdata, me.wdata);
        end
        if (StallM) begin
          scnt++;
          stl_pend = 1'b1;
        end else begin
          chk("stall_cycles", scnt, me.stall);
          scnt = 0;
          cap_pend = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc4);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
    ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction retires.
  task automatic issue(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc4,
                       input logic [31:0] rdata, input int lat);
    int cyc;
    logic st;
    drive(rw, rs, mw, f3, alu, wd, rd, pc4);
    bus.dmem_rdata = rdata;
    q.push_back(model(rw, rs, mw, f3, alu, wd, rd, pc4, rdata, lat));
    cyc = 0;
    while (1) begin
      bus.dmem_ready = (lat >= 0) && (cyc == lat);
      @(negedge clk);
      st = StallM;
      @(posedge clk);
      #1;
      if (!st) break;
      cyc++;
      if (cyc > 200) begin
        chk("stall_bound", 32'(cyc), 0);
        break;
      end
    end
    bus.dmem_ready = 1'b0;
  endtask

  task automatic idle_cycle();
    drive(0, 2'b00, 0, 3'b000, 0, 0, 0, 0);
    @(posedge clk);
    #1;
  endtask

  logic [2:0] f3_tab [5];
  initial begin
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
    reset = 1'b1;
    drive(0, 2'b00, 0, 3'b000, 0, 0, 0, 0);
    bus.dmem_rdata = 32'd0;
    bus.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_StallM", StallM, 0);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_W", {RegWriteW, ResultSrcW, RdW, MisalignW, BusErrW}, 0);
    chk("rst_ALUResultW", ALUResultW, 0);
    chk("rst_ReadDataW", ReadDataW, 0);
    chk("rst_PCPlus4W", PCPlus4W, 0);
    reset = 1'b0;

    // Directed cases.
    issue(1, 2'b00, 0, 3'b000, 32'h1234, 32'h0, 5, 32'h104, 32'h0, 0);
    issue(0, 2'b00, 1, 3'b000, 32'h1003, 32'hAB, 0, 32'h108, 32'h0, 0);
    issue(1, 2'b01, 0, 3'b000, 32'h2001, 32'h0, 7, 32'h10C, 32'h0000_8000, 3);
    issue(1, 2'b01, 0, 3'b100, 32'h2001, 32'h0, 7, 32'h110, 32'h0000_8000, 3);
    issue(1, 2'b01, 0, 3'b010, 32'h0002, 32'h0, 8, 32'h114, 32'h0, 0);
    issue(1, 2'b01, 0, 3'b001, 32'h0003, 32'h0, 8, 32'h118, 32'h0, 0);
    issue(0, 2'b00, 1, 3'b001, 32'h2002, 32'hCDEF, 0, 32'h11C, 32'h0, 1);
    issue(1, 2'b01, 0, 3'b101, 32'h2002, 32'h0, 9, 32'h120, 32'hF00D_1234, 2);
    issue(1, 2'b01, 0, 3'b001, 32'h2002, 32'h0, 9, 32'h124, 32'h8765_1234, 0);
    issue(1, 2'b01, 0, 3'b010, 32'h3000, 32'h0, 10, 32'h128, 32'hDEAD_BEEF, -1);
    issue(1, 2'b01, 0, 3'b010, 32'h3004, 32'h0, 11, 32'h12C, 32'h1111_2222, TO);
    issue(1, 2'b01, 0, 3'b010, 32'h3008, 32'h0, 12, 32'h130, 32'h3333_4444, TO + 1);
    issue(1, 2'b01, 1, 3'b010, 32'h3010, 32'h5555_AAAA, 13, 32'h134, 32'h7777_0000, 1);

    // Reset in the second WAIT cycle.
    idle_cycle();
    idle_cycle();
    drive(1, 2'b00, 0, 3'b000, 32'hDEAD, 0, 3, 32'h200);
    @(posedge clk); #1;
    drive(1, 2'b01, 0, 3'b010, 32'h0040, 0, 4, 32'h204);
    bus.dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_StallM", StallM, 1);
    chk("pre_rst_ALUResultW", ALUResultW, 32'hDEAD);
    reset = 1'b1;
    #1;
    chk("midrst_req", bus.dmem_req, 0);
    chk("midrst_StallM", StallM, 0);
    chk("midrst_W", {RegWriteW, ResultSrcW, RdW, MisalignW, BusErrW}, 0);
    chk("midrst_ALUResultW", ALUResultW, 0);
    chk("midrst_PCPlus4W", PCPlus4W, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(1, 2'b01, 0, 3'b010, 32'h0044, 32'h0, 4, 32'h208, 32'hCAFE_F00D, 1);

    // Randomized instruction mix.
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  rs;
      logic        mw;
      logic [2:0]  f3;
      int          r, lat;
      rs = 2'($urandom_range(0, 3));
      mw = ($urandom_range(0, 3) == 0);
      f3 = mw ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 4)];
      r  = $urandom_range(0, TO + 2);
      lat = (r == TO + 2) ? -1 : r;
      issue(1'($urandom_range(0, 1)), rs, mw, f3, $urandom, $urandom,
            5'($urandom_range(0, 31)), $urandom, $urandom, lat);
    end

    idle_cycle();
    idle_cycle();
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM-stage load/store unit, the consumer of the EX/MEM pipeline register outputs. It turns RegWriteM/ResultSrcM/MemWriteM/ALUResultM/WriteDataM into a valid/ready data-memory transaction, with byte/half alignment and sign extension. It stalls the pipeline while the memory is busy, enforces a wait timeout, and contains the MEM/WB pipeline register feeding the writeback mux.

Parameters:
TIMEOUT, 16, max WAIT cycles before a transaction is aborted (1..255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
RegWriteM  in  1  register write enable from EX/MEM
ResultSrcM  in  2  result select; 2'b01 = load
MemWriteM  in  1  store request
Funct3M  in  3  access size/sign (RV32I load/store funct3)
ALUResultM  in  32  effective address / ALU result
WriteDataM  in  32  store data (rs2)
RdM  in  5  destination register
PCPlus4M  in  32  PC+4
StallM  out  1  hold IF..EX/MEM stages
dmem_req  out  1  bus request valid
dmem_we  out  1  1 = write
dmem_addr  out  32  word address, {ALUResultM[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_wstrb  out  4  byte enables
dmem_rdata  in  32  read data, valid when dmem_ready=1
dmem_ready  in  1  transaction completes at this posedge
RegWriteW  out  1  MEM/WB register write enable
ResultSrcW  out  2  MEM/WB result select
ALUResultW  out  32  MEM/WB ALU result
ReadDataW  out  32  extended load data
RdW  out  5  MEM/WB destination
PCPlus4W  out  32  MEM/WB PC+4
MisalignW  out  1  one-cycle misaligned-access flag
BusErrW  out  1  one-cycle timeout flag

Behaviour:
- Access = load (ResultSrcM==2'b01) or MemWriteM. Load and store both set: store wins, load suppressed.
- Misaligned: half (funct3[1:0]=01) with addr[0]=1, or word (10) with addr[1:0]!=0. Issues no bus request and no stall. Next edge: MisalignW=1, RegWriteW=0.
- Store lanes: SB wdata={4{b}}, wstrb=0001<<addr[1:0]. SH wdata={2{h}}, wstrb=0011<<addr[1:0]. SW wstrb=1111. Loads drive wstrb=0000.
- Load extract: byte/half selected by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Any other funct3 behaves as LW/SW.
- FSM states IDLE, WAIT. Bus outputs are combinational from M inputs, which are stable because StallM freezes EX/MEM.
  - IDLE, aligned access: dmem_req=1, StallM=~dmem_ready. If dmem_ready, complete this edge (zero-wait); else go to WAIT and clear wait counter.
  - WAIT: dmem_req=1, StallM=1, request held unchanged, counter increments per cycle. dmem_ready=1 means complete, StallM=0 that cycle, go to IDLE.
  - WAIT with counter==TIMEOUT-1 and no ready: abort, StallM=0 that cycle, go to IDLE. Next edge: BusErrW=1, RegWriteW=0, ReadDataW=0.
  - Ready and timeout in the same cycle: ready wins.
- MEM/WB register, every posedge:
  - StallM=1: bubble (RegWriteW=0, ResultSrcW=0, MisalignW=0, BusErrW=0); data fields may hold.
  - StallM=0: capture M fields; ReadDataW = extended dmem_rdata on a completed load, else 0.
- Non-memory instructions pass through with 1-cycle latency and never stall.
- Reset (any time, including mid-WAIT): state IDLE, counter 0, all W outputs 0. dmem_req/StallM drop immediately; a pending bus transaction is abandoned.

Test Plan:
- ADD-type pass-through, RegWriteM=1, ALUResultM=0x1234, RdM=5, no access -> next cycle RegWriteW=1, ALUResultW=0x1234, RdW=5, StallM never 1.
- SB addr 0x1003, WriteDataM=0xAB, ready tied 1 -> dmem_wstrb=1000, dmem_wdata=0xABABABAB, dmem_addr=0x1000, no stall.
- LB addr 0x2001, rdata=0x0000_8000, ready after 3 cycles -> StallM high 3 cycles, then ReadDataW=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- LW addr 0x0002 -> dmem_req never asserted, MisalignW=1 one cycle, RegWriteW=0.
- Load with ready held 0, TIMEOUT=4 -> StallM high 4 cycles, then BusErrW=1 one cycle, RegWriteW=0, state back to IDLE.
- Reset asserted in WAIT cycle 2 -> dmem_req and StallM 0 immediately, W outputs 0. Next access after release completes normally.
